// File: rtl/calc_pkg.sv
// Shared encodings for the calculator operand-entry / compute block.
//   top_state_t : states reported by the top-level calculator FSM
//   op_t        : operation select coming from the key decoder
//   eng_state_t : states of the sequential compute engine
package calc_pkg;

   typedef enum logic [2:0] {
      S_FIRST    = 3'd0,
      S_CALCUL   = 3'd1,
      S_SECOND   = 3'd2,
      S_ENTER    = 3'd3,
      S_RESULT   = 3'd4,
      S_CONTINUE = 3'd5
   } top_state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      E_IDLE = 3'd0,
      E_CONV = 3'd1,
      E_EXEC = 3'd2,
      E_B2D  = 3'd3,
      E_DONE = 3'd4
   } eng_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle pulse; bin is sampled and the first shift is done
//   bin      : binary input (W bits)
//   bcd      : BCD output (ND digits), holds its value after completion
//   done     : one-cycle pulse, registered, the cycle after the last shift
// The conversion takes W shift edges including the start edge, so done is
// high during the W-th cycle after start and bcd is valid from then on.
// ND must be large enough for the largest value that will be converted.
module bin2bcd_seq #(
   parameter int W  = 28,
   parameter int ND = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [W-1:0]    bin,
   output logic [4*ND-1:0] bcd,
   output logic            done
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]    sh_q;
   logic [CW-1:0]   cnt_q;
   logic            active_q;
   logic [4*ND-1:0] adj;

   // Add 3 to every digit that is 5 or more before the next left shift.
   always_comb begin
      adj = bcd;
      for (int i = 0; i < ND; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd      <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            // first shift out of an all-zero BCD register needs no adjust
            bcd      <= {{(4*ND-1){1'b0}}, bin[W-1]};
            sh_q     <= bin << 1;
            cnt_q    <= CW'(1);
            active_q <= 1'b1;
         end else if (active_q) begin
            bcd   <= {adj[4*ND-2:0], sh_q[W-1]};
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               active_q <= 1'b0;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/calc_core_seq.sv
// Calculator operand entry and sequential compute engine.
// Ports:
//   clk, esc        : clock, synchronous active-high reset/clear
//   key_valid/code  : digit key pulse (codes 10..15 ignored)
//   cancel          : backspace pulse
//   current_state   : top FSM state (first/calcul/second/enter/result/continue)
//   calcul          : operation, sampled when the engine starts
//   op_a_bcd/op_b_bcd : operands as entered
//   result_bcd/rem_bcd: result magnitude and division remainder in BCD
//   neg, err_div0, ovf: result flags, cleared at start, updated with done
//   busy            : engine active (CONV through DONE)
//   done            : one-cycle pulse when results/flags are updated
// Handshake: the engine starts on the rising edge of current_state==enter
// while idle; busy rises the next cycle and stays high until done, which is
// high for exactly the last busy cycle. Entry/continue are ignored while busy.
module calc_core_seq
   import calc_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int OP_W   = 14
) (
   input  logic                  clk,
   input  logic                  esc,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic                  cancel,
   input  logic [2:0]            current_state,
   input  logic [1:0]            calcul,
   output logic [4*DIGITS-1:0]   op_a_bcd,
   output logic [4*DIGITS-1:0]   op_b_bcd,
   output logic [8*DIGITS-1:0]   result_bcd,
   output logic [4*DIGITS-1:0]   rem_bcd,
   output logic                  neg,
   output logic                  err_div0,
   output logic                  ovf,
   output logic                  busy,
   output logic                  done
);

   localparam int RES_W = 2 * OP_W;
   localparam int CW    = $clog2(DIGITS + 1);
   localparam int SW    = $clog2(OP_W + 1);
   localparam logic [RES_W-1:0] TEN_POW = RES_W'(10 ** DIGITS);

   // ---------------------------------------------------------------
   // Engine state and datapath registers
   // ---------------------------------------------------------------
   eng_state_t           eng_state, eng_next;
   logic [2:0]           prev_state;
   logic [SW-1:0]        step_cnt;
   op_t                  op_q;
   logic [4*DIGITS-1:0]  conv_a, conv_b;
   logic [OP_W-1:0]      acc_a, acc_b;   // acc_a doubles as the quotient
   logic [OP_W-1:0]      div_r;
   logic                 pend_neg, pend_div0, pend_ovf;
   logic                 rem_done_q;

   logic                 start_ev, conv_last, exec_last, b2d_start, b2d_finish;
   logic                 b_zero;
   logic [OP_W:0]        div_sh;
   logic                 div_qbit;
   logic [OP_W-1:0]      div_q_nxt, div_rem_nxt;
   logic [RES_W-1:0]     res_nxt;
   logic [OP_W-1:0]      rem_nxt;
   logic                 sub_neg, div0_nxt, ovf_nxt;

   logic [8*DIGITS-1:0]  res_bcd_w;
   logic [4*DIGITS-1:0]  rem_bcd_w;
   logic                 res_done, rem_done;

   // ---------------------------------------------------------------
   // Entry signals
   // ---------------------------------------------------------------
   logic [CW-1:0]        a_cnt, b_cnt;
   logic                 digit_ev, cancel_ev, cont_ev;
   logic                 a_take, b_take, chain_ok;
   logic [CW-1:0]        chain_cnt;

   assign busy = (eng_state != E_IDLE);
   assign done = (eng_state == E_DONE);

   assign start_ev   = (eng_state == E_IDLE) && (current_state == S_ENTER) &&
                       (prev_state != S_ENTER);
   assign conv_last  = (step_cnt == SW'(DIGITS - 1));
   assign b_zero     = (acc_b == '0);
   assign exec_last  = (op_q != OP_DIV) || b_zero || (step_cnt == SW'(OP_W - 1));
   assign b2d_start  = (eng_state == E_EXEC) && exec_last;
   assign b2d_finish = (eng_state == E_B2D) && res_done && (rem_done_q || rem_done);

   // Engine next-state logic
   always_comb begin
      eng_next = eng_state;
      case (eng_state)
         E_IDLE: if (start_ev)   eng_next = E_CONV;
         E_CONV: if (conv_last)  eng_next = E_EXEC;
         E_EXEC: if (exec_last)  eng_next = E_B2D;
         E_B2D:  if (b2d_finish) eng_next = E_DONE;
         E_DONE:                 eng_next = E_IDLE;
         default:                eng_next = E_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (esc) eng_state <= E_IDLE;
      else     eng_state <= eng_next;
   end

   // Execute-stage arithmetic, including one restoring divide step.
   // The final step result is fed straight into the converters so B2D can
   // begin on the same edge that finishes EXEC.
   always_comb begin
      div_sh   = {div_r, acc_a[OP_W-1]};
      div_qbit = 1'b0;
      if (div_sh >= {1'b0, acc_b}) begin
         div_qbit    = 1'b1;
         div_rem_nxt = OP_W'(div_sh - {1'b0, acc_b});
      end else begin
         div_rem_nxt = div_sh[OP_W-1:0];
      end
      div_q_nxt = {acc_a[OP_W-2:0], div_qbit};

      res_nxt  = '0;
      rem_nxt  = '0;
      sub_neg  = 1'b0;
      div0_nxt = 1'b0;
      case (op_q)
         OP_ADD: res_nxt = RES_W'(acc_a) + RES_W'(acc_b);
         OP_SUB: begin
            if (acc_a >= acc_b) begin
               res_nxt = RES_W'(acc_a - acc_b);
            end else begin
               res_nxt = RES_W'(acc_b - acc_a);
               sub_neg = 1'b1;
            end
         end
         OP_MUL: res_nxt = RES_W'(acc_a) * RES_W'(acc_b);
         OP_DIV: begin
            if (b_zero) begin
               div0_nxt = 1'b1;
            end else begin
               res_nxt = RES_W'(div_q_nxt);
               rem_nxt = div_rem_nxt;
            end
         end
         default: res_nxt = '0;
      endcase
      ovf_nxt = (res_nxt >= TEN_POW);
   end

   // Engine datapath
   always_ff @(posedge clk) begin
      if (esc) begin
         prev_state <= '0;
         step_cnt   <= '0;
         op_q       <= OP_ADD;
         conv_a     <= '0;
         conv_b     <= '0;
         acc_a      <= '0;
         acc_b      <= '0;
         div_r      <= '0;
         pend_neg   <= 1'b0;
         pend_div0  <= 1'b0;
         pend_ovf   <= 1'b0;
         rem_done_q <= 1'b0;
         result_bcd <= '0;
         rem_bcd    <= '0;
         neg        <= 1'b0;
         err_div0   <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         prev_state <= current_state;
         case (eng_state)
            E_IDLE: begin
               if (start_ev) begin
                  step_cnt   <= '0;
                  op_q       <= op_t'(calcul);
                  conv_a     <= op_a_bcd;
                  conv_b     <= op_b_bcd;
                  acc_a      <= '0;
                  acc_b      <= '0;
                  div_r      <= '0;
                  rem_done_q <= 1'b0;
                  neg        <= 1'b0;
                  err_div0   <= 1'b0;
                  ovf        <= 1'b0;
               end
            end
            E_CONV: begin
               // MSD first: acc = acc*10 + digit
               acc_a  <= acc_a * OP_W'(10) + OP_W'(conv_a[4*DIGITS-1 -: 4]);
               acc_b  <= acc_b * OP_W'(10) + OP_W'(conv_b[4*DIGITS-1 -: 4]);
               conv_a <= conv_a << 4;
               conv_b <= conv_b << 4;
               step_cnt <= conv_last ? '0 : step_cnt + SW'(1);
            end
            E_EXEC: begin
               if ((op_q == OP_DIV) && !b_zero) begin
                  acc_a    <= div_q_nxt;
                  div_r    <= div_rem_nxt;
                  step_cnt <= step_cnt + SW'(1);
               end
               if (exec_last) begin
                  pend_neg  <= sub_neg;
                  pend_div0 <= div0_nxt;
                  pend_ovf  <= ovf_nxt;
               end
            end
            E_B2D: begin
               if (rem_done) rem_done_q <= 1'b1;
               if (b2d_finish) begin
                  result_bcd <= res_bcd_w;
                  rem_bcd    <= rem_bcd_w;
                  neg        <= pend_neg;
                  err_div0   <= pend_div0;
                  ovf        <= pend_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   // The result can need 2*DIGITS digits; the remainder is below B.
   bin2bcd_seq #(.W(RES_W), .ND(2*DIGITS)) u_res_b2d (
      .clk   (clk),
      .rst   (esc),
      .start (b2d_start),
      .bin   (res_nxt),
      .bcd   (res_bcd_w),
      .done  (res_done)
   );

   bin2bcd_seq #(.W(OP_W), .ND(DIGITS)) u_rem_b2d (
      .clk   (clk),
      .rst   (esc),
      .start (b2d_start),
      .bin   (rem_nxt),
      .bcd   (rem_bcd_w),
      .done  (rem_done)
   );

   // ---------------------------------------------------------------
   // Operand entry
   // ---------------------------------------------------------------
   assign digit_ev  = key_valid && (key_code <= 4'd9) && !busy;
   assign cancel_ev = cancel && !busy;
   assign cont_ev   = (current_state == S_CONTINUE) && !busy;
   assign chain_ok  = !(neg || err_div0 || ovf);

   // leading zeros and digits beyond the limit are swallowed
   assign a_take = !((key_code == 4'd0) && (a_cnt == '0)) && (a_cnt != CW'(DIGITS));
   assign b_take = !((key_code == 4'd0) && (b_cnt == '0)) && (b_cnt != CW'(DIGITS));

   // Significant digits of the chained result: position of the highest
   // nonzero digit in the low DIGITS digits.
   always_comb begin
      chain_cnt = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (result_bcd[4*i +: 4] != 4'd0) chain_cnt = CW'(i + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (esc) begin
         op_a_bcd <= '0;
         a_cnt    <= '0;
         op_b_bcd <= '0;
         b_cnt    <= '0;
      end else if (cont_ev) begin
         op_b_bcd <= '0;
         b_cnt    <= '0;
         if (chain_ok) begin
            op_a_bcd <= result_bcd[4*DIGITS-1:0];
            a_cnt    <= chain_cnt;
         end else begin
            op_a_bcd <= '0;
            a_cnt    <= '0;
         end
      end else if (current_state == S_FIRST) begin
         if (digit_ev) begin
            if (a_take) begin
               op_a_bcd <= {op_a_bcd[4*DIGITS-5:0], key_code};
               a_cnt    <= a_cnt + CW'(1);
            end
         end else if (cancel_ev && (a_cnt != '0)) begin
            op_a_bcd <= op_a_bcd >> 4;
            a_cnt    <= a_cnt - CW'(1);
         end
      end else if (current_state == S_SECOND) begin
         if (digit_ev) begin
            if (b_take) begin
               op_b_bcd <= {op_b_bcd[4*DIGITS-5:0], key_code};
               b_cnt    <= b_cnt + CW'(1);
            end
         end else if (cancel_ev && (b_cnt != '0)) begin
            op_b_bcd <= op_b_bcd >> 4;
            b_cnt    <= b_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_calc_core_seq.sv
// Directed bench for calc_core_seq (DIGITS=4, OP_W=14).
module tb_calc_core_seq;

   localparam int LAT_ARITH = 4 + 1 + 28 + 1;
   localparam int LAT_DIV   = 4 + 14 + 28 + 1;

   logic        clk = 1'b0;
   logic        esc = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        cancel = 1'b0;
   logic [2:0]  current_state = 3'd0;
   logic [1:0]  calcul = 2'b00;
   logic [15:0] op_a_bcd, op_b_bcd, rem_bcd;
   logic [31:0] result_bcd;
   logic        neg, err_div0, ovf, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   calc_core_seq #(.DIGITS(4), .OP_W(14)) dut (
      .clk           (clk),
      .esc           (esc),
      .key_valid     (key_valid),
      .key_code      (key_code),
      .cancel        (cancel),
      .current_state (current_state),
      .calcul        (calcul),
      .op_a_bcd      (op_a_bcd),
      .op_b_bcd      (op_b_bcd),
      .result_bcd    (result_bcd),
      .rem_bcd       (rem_bcd),
      .neg           (neg),
      .err_div0      (err_div0),
      .ovf           (ovf),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic do_esc();
      esc = 1'b1;
      @(negedge clk);
      esc = 1'b0;
   endtask

   task automatic press_key(input logic [3:0] d, input logic with_cancel);
      key_valid = 1'b1;
      key_code  = d;
      cancel    = with_cancel;
      @(negedge clk);
      key_valid = 1'b0;
      cancel    = 1'b0;
   endtask

   task automatic press_cancel();
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
   endtask

   task automatic type_num(input int n);
      int d[8];
      int nd;
      int v;
      nd = 0;
      v  = n;
      if (v == 0) begin
         press_key(4'd0, 1'b0);
      end else begin
         while (v > 0 && nd < 8) begin
            d[nd] = v % 10;
            v     = v / 10;
            nd++;
         end
         for (int i = nd - 1; i >= 0; i--) press_key(4'(d[i]), 1'b0);
      end
   endtask

   task automatic load_operands(input int a, input logic [1:0] op, input int b);
      current_state = 3'd0;
      type_num(a);
      current_state = 3'd1;
      calcul        = op;
      @(negedge clk);
      current_state = 3'd2;
      type_num(b);
   endtask

   // Cycles counted from the start edge (1) to the first cycle done is seen.
   task automatic run_calc(input int a, input logic [1:0] op, input int b, output int lat);
      load_operands(a, op, b);
      current_state = 3'd3;
      lat = 0;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      @(negedge clk);
      current_state = 3'd4;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      esc = 1'b1;
      repeat (2) @(negedge clk);
      esc = 1'b0;
      n_checks++; if (op_a_bcd !== 16'h0) begin n_fail++; $display("FAIL reset_op_a got %h exp 0000", op_a_bcd); end
      n_checks++; if (op_b_bcd !== 16'h0) begin n_fail++; $display("FAIL reset_op_b got %h exp 0000", op_b_bcd); end
      n_checks++; if (result_bcd !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result_bcd); end
      n_checks++; if ({neg, err_div0, ovf, busy, done} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags got %b exp 00000", {neg, err_div0, ovf, busy, done});
      end
   endtask

   task automatic test_entry();
      do_esc();
      current_state = 3'd0;
      press_key(4'd0, 1'b0); press_key(4'd0, 1'b0);
      press_key(4'd1, 1'b0); press_key(4'd2, 1'b0);
      press_key(4'd3, 1'b0); press_key(4'd4, 1'b0);
      press_key(4'd5, 1'b0);
      n_checks++; if (op_a_bcd !== 16'h1234) begin n_fail++; $display("FAIL entry_limit got %h exp 1234", op_a_bcd); end
      press_cancel(); press_cancel();
      n_checks++; if (op_a_bcd !== 16'h0012) begin n_fail++; $display("FAIL entry_cancel got %h exp 0012", op_a_bcd); end
      press_key(4'd9, 1'b1);
      n_checks++; if (op_a_bcd !== 16'h0129) begin n_fail++; $display("FAIL entry_key_wins got %h exp 0129", op_a_bcd); end
      press_key(4'd12, 1'b0);
      n_checks++; if (op_a_bcd !== 16'h0129) begin n_fail++; $display("FAIL entry_bad_code got %h exp 0129", op_a_bcd); end
      repeat (4) press_cancel();
      n_checks++; if (op_a_bcd !== 16'h0000) begin n_fail++; $display("FAIL entry_cancel_empty got %h exp 0000", op_a_bcd); end
      current_state = 3'd2;
      press_key(4'd7, 1'b0);
      n_checks++; if (op_b_bcd !== 16'h0007 || op_a_bcd !== 16'h0000) begin
         n_fail++; $display("FAIL entry_to_b got a=%h b=%h exp a=0000 b=0007", op_a_bcd, op_b_bcd);
      end
   endtask

   task automatic test_add();
      int lat;
      do_esc();
      run_calc(1234, 2'b00, 5678, lat);
      n_checks++; if (lat !== LAT_ARITH) begin n_fail++; $display("FAIL add_latency got %0d exp %0d", lat, LAT_ARITH); end
      n_checks++; if (result_bcd !== 32'h00006912) begin n_fail++; $display("FAIL add_result got %h exp 00006912", result_bcd); end
      n_checks++; if ({neg, err_div0, ovf, busy, done} !== 5'b0 || rem_bcd !== 16'h0) begin
         n_fail++; $display("FAIL add_flags got %b rem %h exp 00000 rem 0000", {neg, err_div0, ovf, busy, done}, rem_bcd);
      end
   endtask

   task automatic test_sub_continue();
      int lat;
      do_esc();
      run_calc(12, 2'b01, 345, lat);
      n_checks++; if (result_bcd !== 32'h00000333) begin n_fail++; $display("FAIL sub_result got %h exp 00000333", result_bcd); end
      n_checks++; if (neg !== 1'b1) begin n_fail++; $display("FAIL sub_neg got %b exp 1", neg); end
      current_state = 3'd5;
      @(negedge clk);
      n_checks++; if (op_a_bcd !== 16'h0 || op_b_bcd !== 16'h0) begin
         n_fail++; $display("FAIL sub_continue got a=%h b=%h exp 0000 0000", op_a_bcd, op_b_bcd);
      end
   endtask

   task automatic test_mul_ovf();
      int lat;
      do_esc();
      run_calc(9999, 2'b10, 9999, lat);
      n_checks++; if (lat !== LAT_ARITH) begin n_fail++; $display("FAIL mul_latency got %0d exp %0d", lat, LAT_ARITH); end
      n_checks++; if (result_bcd !== 32'h99980001) begin n_fail++; $display("FAIL mul_result got %h exp 99980001", result_bcd); end
      n_checks++; if (ovf !== 1'b1 || neg !== 1'b0) begin n_fail++; $display("FAIL mul_ovf got ovf=%b neg=%b exp 1 0", ovf, neg); end
   endtask

   task automatic test_div();
      int lat;
      do_esc();
      run_calc(1000, 2'b11, 7, lat);
      n_checks++; if (lat !== LAT_DIV) begin n_fail++; $display("FAIL div_latency got %0d exp %0d", lat, LAT_DIV); end
      n_checks++; if (result_bcd !== 32'h00000142) begin n_fail++; $display("FAIL div_result got %h exp 00000142", result_bcd); end
      n_checks++; if (rem_bcd !== 16'h0006) begin n_fail++; $display("FAIL div_rem got %h exp 0006", rem_bcd); end
      n_checks++; if ({neg, err_div0, ovf} !== 3'b0) begin n_fail++; $display("FAIL div_flags got %b exp 000", {neg, err_div0, ovf}); end
   endtask

   task automatic test_div0_chain();
      int lat;
      do_esc();
      run_calc(100, 2'b11, 0, lat);
      n_checks++; if (lat !== LAT_ARITH) begin n_fail++; $display("FAIL div0_latency got %0d exp %0d", lat, LAT_ARITH); end
      n_checks++; if (result_bcd !== 32'h0 || rem_bcd !== 16'h0) begin
         n_fail++; $display("FAIL div0_values got %h rem %h exp 0 0", result_bcd, rem_bcd);
      end
      n_checks++; if (err_div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag got %b exp 1", err_div0); end
      current_state = 3'd5;
      @(negedge clk);
      n_checks++; if (op_a_bcd !== 16'h0) begin n_fail++; $display("FAIL div0_continue got %h exp 0000", op_a_bcd); end
      run_calc(25, 2'b00, 17, lat);
      n_checks++; if (result_bcd !== 32'h00000042 || err_div0 !== 1'b0) begin
         n_fail++; $display("FAIL chain_add got %h div0=%b exp 00000042 0", result_bcd, err_div0);
      end
      current_state = 3'd5;
      @(negedge clk);
      n_checks++; if (op_a_bcd !== 16'h0042 || op_b_bcd !== 16'h0) begin
         n_fail++; $display("FAIL chain_continue got a=%h b=%h exp 0042 0000", op_a_bcd, op_b_bcd);
      end
      current_state = 3'd0;
      press_key(4'd1, 1'b0);
      n_checks++; if (op_a_bcd !== 16'h0421) begin n_fail++; $display("FAIL chain_count got %h exp 0421", op_a_bcd); end
   endtask

   task automatic test_esc_mid_div();
      int dones;
      do_esc();
      load_operands(1000, 2'b11, 7);
      current_state = 3'd3;
      repeat (20) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL middiv_busy got %b exp 1", busy); end
      current_state = 3'd2;
      press_key(4'd5, 1'b0);
      press_cancel();
      current_state = 3'd0;
      press_key(4'd3, 1'b0);
      n_checks++; if (op_b_bcd !== 16'h0007 || op_a_bcd !== 16'h1000) begin
         n_fail++; $display("FAIL busy_keys got a=%h b=%h exp 1000 0007", op_a_bcd, op_b_bcd);
      end
      do_esc();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL esc_busy got busy=%b done=%b exp 0 0", busy, done); end
      n_checks++; if (op_a_bcd !== 16'h0 || op_b_bcd !== 16'h0 || result_bcd !== 32'h0 || rem_bcd !== 16'h0 ||
                      {neg, err_div0, ovf} !== 3'b0) begin
         n_fail++; $display("FAIL esc_outputs got a=%h b=%h r=%h rem=%h f=%b exp all 0",
                            op_a_bcd, op_b_bcd, result_bcd, rem_bcd, {neg, err_div0, ovf});
      end
      dones = 0;
      repeat (60) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL esc_no_done got %0d active cycles exp 0", dones); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_entry();
      test_add();
      test_sub_continue();
      test_mul_ovf();
      test_div();
      test_div0_chain();
      test_esc_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_core_seq.md
Name: calc_core_seq

Overview:
Parametrised successor to the calculator operand-entry/compute block.
- Accepts BCD digit entry for two operands of DIGITS digits, with digit limit and backspace.
- Converts the operands to binary sequentially and runs the four operations.
- The divide is multi-cycle restoring.
- The binary result is converted back to BCD for the display path.
- Adds sign, divide-by-zero and overflow flags plus a busy/done handshake. Sits between the key decoder/top FSM and the display driver.

Parameters:
DIGITS, 4, decimal digits per operand (2..8)
OP_W, 14, operand binary width; must satisfy 2^OP_W > 10^DIGITS-1
RES_W, 2*OP_W, result binary width (localparam, not overridable)

Ports:
clk  in  1  system clock
esc  in  1  synchronous active-high reset/clear, sampled on rising clk
key_valid  in  1  one-cycle pulse: key_code holds a digit
key_code  in  4  digit 0..9; codes 10..15 ignored
cancel  in  1  one-cycle backspace pulse
current_state  in  3  top FSM state: 0 first, 1 calcul, 2 second, 3 enter, 4 result, 5 continue
calcul  in  2  00 add, 01 sub, 10 mul, 11 div
op_a_bcd  out  4*DIGITS  operand A digits as entered
op_b_bcd  out  4*DIGITS  operand B digits as entered
result_bcd  out  8*DIGITS  result magnitude, BCD
rem_bcd  out  4*DIGITS  division remainder, BCD (0 for other ops)
neg  out  1  result negative (sub with A<B)
err_div0  out  1  divide by zero
ovf  out  1  result magnitude >= 10^DIGITS (cannot chain as operand)
busy  out  1  compute engine active
done  out  1  one-cycle pulse when result_bcd/flags valid

Behaviour:
- Reset (esc=1): all outputs 0; digit counts 0; engine to IDLE. Applies mid-computation and aborts it with no done pulse.
- Entry:
  - Only when busy=0. In state 0 entry goes to A; in state 2 it goes to B.
  - A digit shifts in at the LSD and increments the count.
  - A 0 digit with count 0 is a leading zero: value and count are unchanged.
  - With count==DIGITS, further digits are ignored (no shift-out).
  - cancel shifts right by one digit and decrements the count; ignored at count 0.
  - key_valid and cancel in the same cycle: the digit wins.
- Start: the engine starts on the first clk where current_state==3 and the previous sample was !=3 (edge-detected). Repeated 3s do not restart it.
- Engine FSM: IDLE -> CONV -> EXEC -> B2D -> DONE -> IDLE.
  - CONV: DIGITS cycles, MSD first, acc = acc*10 + digit, A and B in parallel.
  - EXEC:
    - add/sub/mul take 1 cycle.
    - div takes OP_W cycles of restoring shift-subtract (quotient OP_W bits, remainder OP_W bits).
    - div with B==0 takes 1 cycle: quotient=0, remainder=0, err_div0=1.
  - B2D: double-dabble; RES_W cycles for the result and, in parallel, for the remainder (OP_W bits, finished early).
  - DONE: 1 cycle; done=1, outputs updated the same edge; then back to IDLE.
- busy=1 from the cycle after start through DONE inclusive.
- Latency, start edge to done: DIGITS + 1 + RES_W + 1 for add/sub/mul; DIGITS + OP_W + RES_W + 1 for div.
- Sub: if A>=B result = A-B, neg=0; else result = B-A, neg=1.
- ovf=1 when result >= 10^DIGITS. Magnitude is always exact within 2*DIGITS digits.
- Flags hold until the next start or esc; they are cleared at start.
- Continue (state 5, busy=0):
  - If neg|err_div0|ovf = 0, A is loaded with the low DIGITS digits of result_bcd and the A count is set to the number of significant digits.
  - Otherwise A and its count are cleared.
  - In both cases B and its count are cleared.
- Any entry or continue event while busy=1 is ignored.

Decomposition:
- Package calc_pkg: state encodings (S_FIRST..S_CONTINUE), op encodings (OP_ADD..OP_DIV), engine state enum.
- Natural sub-module: bin2bcd_seq (parametrised width, start/done, double-dabble), instantiated twice (result, remainder).
- Operand entry registers and the divider stay inline.

Test Plan:
- Enter 1234, op 00, enter 5678, state 3 -> done after 4+1+28+1=34 cycles; result_bcd=00006912, flags 0.
- 12 sub 345 -> result_bcd=00000333, neg=1; then state 5 -> op_a_bcd=0000, op_b_bcd=0000.
- 9999 mul 9999 -> result_bcd=99980001, ovf=1; 1000 div 7 -> result 00000142, rem_bcd=0006, done after 4+14+28+1=47 cycles.
- 100 div 0 -> result 0, rem 0, err_div0=1; then 25 add 17, continue -> op_a_bcd=0042.
- Keys 0,0,1,2,3,4,5 -> op_a_bcd=1234 (leading zeros and 5th digit ignored); cancel,cancel -> 0012; key and cancel same cycle with key 9 -> 0129.
- esc asserted mid-divide -> next cycle busy=0, all outputs 0, no done pulse; keys during busy produce no change.
